// File: rtl/gcd_stein_responder_pkg.sv
// Shared definitions for the binary-GCD responder: FSM encodings and sizing helpers.
package gcd_stein_responder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STRIP  = 3'd1,
    ST_REDUCE = 3'd2,
    ST_FIXUP  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Shift counter must reach WIDTH-1 without wrapping.
  function automatic int k_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/gcd_stein_step.sv
// One Stein iteration: next (a, b, k) and a phase-complete flag for STRIP or REDUCE.
module gcd_stein_step #(
  parameter int WIDTH = 8,
  parameter int KW    = 4
) (
  input  logic             strip_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] b_nxt,
  output logic [KW-1:0]    k_nxt,
  output logic             done
);

  always_comb begin
    a_nxt = a;
    b_nxt = b;
    k_nxt = k;
    done  = 1'b0;
    if (strip_mode) begin
      if (!a[0] && !b[0]) begin
        a_nxt = a >> 1;
        b_nxt = b >> 1;
        k_nxt = k + KW'(1);
      end else begin
        done = 1'b1;
      end
    end else begin
      // Odd/odd differences are even, so every subtract is followed by a shift.
      if (!a[0]) begin
        a_nxt = a >> 1;
      end else if (!b[0]) begin
        b_nxt = b >> 1;
      end else if (a == b) begin
        done = 1'b1;
      end else if (a > b) begin
        a_nxt = a - b;
      end else begin
        b_nxt = b - a;
      end
    end
  end

endmodule

// File: rtl/gcd_stein_responder.sv
// Valid/ready responder computing gcd(in0, in1) with binary GCD, one step per cycle.
module gcd_stein_responder
  import gcd_stein_responder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out0
);

  localparam int KW = k_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] out0_q, out0_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] step_a, step_b;
  logic [KW-1:0]    step_k;
  logic             step_done;

  gcd_stein_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_step (
    .strip_mode (state_q == ST_STRIP),
    .a          (a_q),
    .b          (b_q),
    .k          (k_q),
    .a_nxt      (step_a),
    .b_nxt      (step_b),
    .k_nxt      (step_k),
    .done       (step_done)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    k_d         = k_q;
    out0_d      = out0_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (in_valid) begin
          a_d        = in0;
          b_d        = in1;
          k_d        = '0;
          in_ready_d = 1'b0;
          // A zero operand short-circuits: the answer is the other operand.
          if (in0 == '0 || in1 == '0) begin
            out0_d      = in0 | in1;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            state_d = ST_STRIP;
          end
        end
      end
      ST_STRIP: begin
        a_d = step_a;
        b_d = step_b;
        k_d = step_k;
        if (step_done) state_d = ST_REDUCE;
      end
      ST_REDUCE: begin
        a_d = step_a;
        b_d = step_b;
        if (step_done) state_d = ST_FIXUP;
      end
      ST_FIXUP: begin
        out0_d      = a_q << k_q;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      k_q         <= '0;
      out0_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      k_q         <= k_d;
      out0_q      <= out0_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out0      = out0_q;

endmodule

// File: tb/tb_gcd_stein_responder.sv
// Directed and swept checks of the binary-GCD responder against a Euclid reference.
module tb_gcd_stein_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in0, in1;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out0;

  int total = 0;
  int bad   = 0;

  gcd_stein_responder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in0),
    .in1       (in1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0      (out0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_gcd(input int x, input int y);
    int p = x;
    int q = y;
    int t;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Offer one pair with out_ready held high and check result, latency and return to idle.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [7:0] e);
    int lat;
    int waited;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check($sformatf("idle_wait(%0d,%0d)", x, y), int'(in_ready), 1);
    in0 = x;
    in1 = y;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in0 = 8'hA5;
    in1 = 8'h5A;
    check($sformatf("busy_ready(%0d,%0d)", x, y), int'(in_ready), 0);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("out_valid(%0d,%0d)", x, y), int'(out_valid), 1);
    check($sformatf("out0(%0d,%0d)", x, y), int'(out0), int'(e));
    if (x == 8'd0 || y == 8'd0)
      check($sformatf("lat_zero(%0d,%0d)", x, y), lat, 1);
    else
      check($sformatf("lat_le35(%0d,%0d) lat=%0d", x, y, lat), int'(lat <= 35), 1);
    @(posedge clk); #1;
    check($sformatf("ov_drop(%0d,%0d)", x, y), int'(out_valid), 0);
    check($sformatf("ready_back(%0d,%0d)", x, y), int'(in_ready), 1);
  endtask

  vec_t vecs[16];

  initial begin
    int waited;
    logic seen;

    vecs[0]  = '{8'd48,  8'd18,  8'd6};
    vecs[1]  = '{8'd0,   8'd0,   8'd0};
    vecs[2]  = '{8'd0,   8'd7,   8'd7};
    vecs[3]  = '{8'd9,   8'd0,   8'd9};
    vecs[4]  = '{8'd128, 8'd96,  8'd32};
    vecs[5]  = '{8'd255, 8'd255, 8'd255};
    vecs[6]  = '{8'd255, 8'd1,   8'd1};
    vecs[7]  = '{8'd1,   8'd255, 8'd1};
    vecs[8]  = '{8'd17,  8'd51,  8'd17};
    vecs[9]  = '{8'd100, 8'd75,  8'd25};
    vecs[10] = '{8'd64,  8'd48,  8'd16};
    vecs[11] = '{8'd13,  8'd7,   8'd1};
    vecs[12] = '{8'd240, 8'd180, 8'd60};
    vecs[13] = '{8'd81,  8'd27,  8'd27};
    vecs[14] = '{8'd128, 8'd128, 8'd128};
    vecs[15] = '{8'd2,   8'd254, 8'd2};

    in_valid  = 1'b0;
    in0       = 8'd0;
    in1       = 8'd0;
    out_ready = 1'b1;
    rst       = 1'b1;
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out0", int'(out0), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].exp);

    // Result held stable under backpressure while operands and in_valid wiggle.
    out_ready = 1'b0;
    in0 = 8'd12;
    in1 = 8'd8;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waited = 0;
    while (!out_valid && waited < 60) begin
      @(posedge clk); #1;
      waited++;
    end
    check("bp_out_valid", int'(out_valid), 1);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_hold_valid[%0d]", c), int'(out_valid), 1);
      check($sformatf("bp_hold_out0[%0d]", c), int'(out0), 4);
      check($sformatf("bp_hold_ready[%0d]", c), int'(in_ready), 0);
      in_valid = 1'b1;
      in0 = 8'($urandom_range(1, 255));
      in1 = 8'($urandom_range(1, 255));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_final_out0", int'(out0), 4);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", int'(out_valid), 0);
    check("bp_release_ready", int'(in_ready), 1);

    // Async reset mid-computation discards the operation.
    in0 = 8'd200;
    in1 = 8'd150;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_result", int'(seen), 0);
    run_op(8'd21, 8'd14, 8'd7);

    // Swept operands against the Euclid reference, with latency bound.
    for (int i = 0; i < 256; i += 17)
      for (int j = 0; j < 256; j += 5)
        run_op(8'(i), 8'(j), 8'(ref_gcd(i, j)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
